// File: rtl/matrix_unit_arbiter_if.sv
// Handshake bundle between requesters, the shared matrix unit and matrix_unit_arbiter.
// The arbiter connects to the slave modport; requesters and the unit model connect to master.
interface matrix_unit_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [1:0]         sel;
    logic               unit_en;
    logic               unit_busy;
    logic [NUM_REQ-1:0] done;
    logic               result_valid;
    logic [NUM_REQ-1:0] err;
    logic               active;

    modport slave (
        input  req, unit_busy,
        output grant, sel, unit_en, done, result_valid, err, active
    );

    modport master (
        output req, unit_busy,
        input  grant, sel, unit_en, done, result_valid, err, active
    );
endinterface

// File: rtl/matrix_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one matrix unit among up to four requesters.
// Optional launch/run timeout abort is compiled in with ARB_TIMEOUT_EN.
module matrix_unit_arbiter #(
    parameter int unsigned NUM_REQ = 4
`ifdef ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    matrix_unit_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_HOLD, S_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic               unit_en_q, unit_en_d;
    logic               rv_q, rv_d;
    logic               active_q;
    logic               pick_found;
    logic [1:0]         pick_idx;
    logic [2:0]         scan_idx;
    logic               req_held;
    logic               timeout_fire;

    // Granted requester still holding its request
    assign req_held = |(bus.req & grant_q);

    // First set request at or above rr_ptr, wrapping within NUM_REQ
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = 3'(rr_ptr_q) + 3'(i);
            if (scan_idx >= 3'(NUM_REQ)) begin
                scan_idx = scan_idx - 3'(NUM_REQ);
            end
            if (!pick_found && bus.req[scan_idx[1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[1:0];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0]         cnt_q;
    logic [NUM_REQ-1:0] err_q;

    // Completion in RUN takes priority over an expiring counter
    assign timeout_fire = (cnt_q == 8'(TIMEOUT_CYCLES - 1)) &&
                          ((state_q == S_LAUNCH) || (state_q == S_RUN && bus.unit_busy));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            err_q <= timeout_fire ? grant_q : '0;
            if (state_q == S_LAUNCH || state_q == S_RUN) begin
                cnt_q <= cnt_q + 8'd1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_fire = 1'b0;
    assign bus.err      = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            sel_q     <= '0;
            rr_ptr_q  <= '0;
            unit_en_q <= 1'b0;
            rv_q      <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            sel_q     <= sel_d;
            rr_ptr_q  <= rr_ptr_d;
            unit_en_q <= unit_en_d;
            rv_q      <= rv_d;
            active_q  <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        unit_en_d = unit_en_q;
        rv_d      = rv_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d   = S_LAUNCH;
                    grant_d   = NUM_REQ'(1) << pick_idx;
                    sel_d     = pick_idx;
                    unit_en_d = 1'b1;
                    rr_ptr_d  = (pick_idx == 2'(NUM_REQ - 1)) ? 2'd0 : pick_idx + 2'd1;
                end
            end
            S_LAUNCH: begin
                if (timeout_fire) begin
                    state_d   = S_RELEASE;
                    grant_d   = '0;
                    unit_en_d = 1'b0;
                end else if (bus.unit_busy) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.unit_busy) begin
                    state_d = S_HOLD;
                    done_d  = grant_q;
                    rv_d    = 1'b1;
                end else if (timeout_fire) begin
                    state_d   = S_RELEASE;
                    grant_d   = '0;
                    unit_en_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (!req_held) begin
                    state_d   = S_RELEASE;
                    grant_d   = '0;
                    unit_en_d = 1'b0;
                    rv_d      = 1'b0;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.grant        = grant_q;
    assign bus.sel          = sel_q;
    assign bus.unit_en      = unit_en_q;
    assign bus.done         = done_q;
    assign bus.result_valid = rv_q;
    assign bus.active       = active_q;
endmodule
